// File: rtl/systolic_weight_loader.sv
// systolic_weight_loader: streams weight row-vectors down the north edge of a
// WxW systolic array. Each accepted row is tagged with its target PE row index
// and an accept-weight strobe. Unused rows can be zero-filled. A done pulse is
// raised once the last strobe has reached the bottom PE row.
module systolic_weight_loader #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8,
    localparam int W    = SYSTOLIC_ARRAY_WIDTH,
    localparam int DW   = DATA_WIDTH_IN,
    localparam int IDXW = $clog2(SYSTOLIC_ARRAY_WIDTH),
    localparam int CNTW = $clog2(SYSTOLIC_ARRAY_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wl_start,
    input  logic [CNTW-1:0]     wl_num_rows,
    input  logic                wl_zero_fill,
    // Row handshake: a row-vector transfers in every cycle where both
    // wl_row_valid and wl_row_ready are high at the rising clock edge.
    // wl_row_ready depends only on state, never on wl_row_valid, and a
    // producer may hold or drop valid freely.
    input  logic                wl_row_valid,
    output logic                wl_row_ready,
    input  logic [W*DW-1:0]     wl_row_data,
    output logic [W*DW-1:0]     wl_weight_out,
    output logic [W*IDXW-1:0]   wl_index_out,
    output logic [W-1:0]        wl_accept_w_out,
    output logic                wl_busy,
    output logic                wl_done,
    output logic [2:0]          wl_state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNTW-1:0] ROWS_MAX   = CNTW'(W);
    localparam logic [CNTW-1:0] LAST_ROW   = CNTW'(W - 1);
    // DRAIN lasts W-1 cycles: counter runs 0..W-2.
    localparam logic [IDXW-1:0] DRAIN_LAST = IDXW'(W - 2);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   num_rows_q, num_rows_d;
    logic              zero_fill_q, zero_fill_d;
    logic [CNTW-1:0]   row_cnt_q, row_cnt_d;
    logic [IDXW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [W*DW-1:0]   weight_q, weight_d;
    logic [IDXW-1:0]   index_q, index_d;
    logic              accept_q, accept_d;
    logic              done_q, done_d;

    logic [CNTW-1:0]   row_cnt_inc;
    logic              row_hs;

    assign row_cnt_inc = row_cnt_q + CNTW'(1);
    assign row_hs      = wl_row_valid && (state_q == ST_LOAD);

    // Next-state, counter and output-register update logic.
    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        zero_fill_d = zero_fill_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = '0;
        weight_d    = '0;
        index_d     = '0;
        accept_d    = 1'b0;
        // The done pulse is registered, so it lands one cycle after DONE.
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (wl_start) begin
                    num_rows_d  = (wl_num_rows > ROWS_MAX) ? ROWS_MAX : wl_num_rows;
                    zero_fill_d = wl_zero_fill;
                    row_cnt_d   = '0;
                    if (wl_num_rows == '0) begin
                        state_d = wl_zero_fill ? ST_FILL : ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (row_hs) begin
                    weight_d  = wl_row_data;
                    index_d   = row_cnt_q[IDXW-1:0];
                    accept_d  = 1'b1;
                    row_cnt_d = row_cnt_inc;
                    if (row_cnt_inc == num_rows_q) begin
                        state_d = (zero_fill_q && (row_cnt_inc < ROWS_MAX)) ? ST_FILL : ST_DRAIN;
                    end
                end
            end
            ST_FILL: begin
                index_d   = row_cnt_q[IDXW-1:0];
                accept_d  = 1'b1;
                row_cnt_d = row_cnt_inc;
                if (row_cnt_q == LAST_ROW) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered north-edge outputs; async reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_rows_q  <= '0;
            zero_fill_q <= 1'b0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            weight_q    <= '0;
            index_q     <= '0;
            accept_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            zero_fill_q <= zero_fill_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            weight_q    <= weight_d;
            index_q     <= index_d;
            accept_q    <= accept_d;
            done_q      <= done_d;
        end
    end

    // Every column receives the same index and strobe; busy covers the done pulse.
    assign wl_row_ready    = (state_q == ST_LOAD);
    assign wl_busy         = (state_q != ST_IDLE) || done_q;
    assign wl_done         = done_q;
    assign wl_weight_out   = weight_q;
    assign wl_index_out    = {W{index_q}};
    assign wl_accept_w_out = {W{accept_q}};
    assign wl_state_dbg    = state_q;

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Directed testbench for systolic_weight_loader with W=4, DW=8. A small model
// of a 4x4 PE array (weights shifting one row per cycle) checks what actually
// lands in each PE's inactive register.
module tb_systolic_weight_loader;

    localparam int W    = 4;
    localparam int DW   = 8;
    localparam int IDXW = 2;
    localparam int CNTW = 3;

    // Clock/reset and DUT signals
    logic                clk;
    logic                rst_n;
    logic                wl_start;
    logic [CNTW-1:0]     wl_num_rows;
    logic                wl_zero_fill;
    logic                wl_row_valid;
    logic                wl_row_ready;
    logic [W*DW-1:0]     wl_row_data;
    logic [W*DW-1:0]     wl_weight_out;
    logic [W*IDXW-1:0]   wl_index_out;
    logic [W-1:0]        wl_accept_w_out;
    logic                wl_busy;
    logic                wl_done;
    logic [2:0]          wl_state_dbg;

    systolic_weight_loader #(
        .SYSTOLIC_ARRAY_WIDTH (W),
        .DATA_WIDTH_IN        (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wl_start        (wl_start),
        .wl_num_rows     (wl_num_rows),
        .wl_zero_fill    (wl_zero_fill),
        .wl_row_valid    (wl_row_valid),
        .wl_row_ready    (wl_row_ready),
        .wl_row_data     (wl_row_data),
        .wl_weight_out   (wl_weight_out),
        .wl_index_out    (wl_index_out),
        .wl_accept_w_out (wl_accept_w_out),
        .wl_busy         (wl_busy),
        .wl_done         (wl_done),
        .wl_state_dbg    (wl_state_dbg)
    );

    always #5 clk = ~clk;

    int checks;
    int passes;
    int cyc;
    int start_cyc;

    // Row data: row r, column c byte = {r, c+1}
    logic [W*DW-1:0] rows [W];

    // PE array model: pipeline of north-edge values and inactive weights
    logic [DW-1:0]   pe [W][W];
    logic [DW-1:0]   pw [W][W];
    logic [IDXW-1:0] pi [W][W];
    logic            pa [W][W];

    // Recorded observations (cycles relative to the start cycle)
    int              acc_cyc_q[$];
    logic [W*IDXW-1:0] acc_idx_q[$];
    logic [W*DW-1:0] acc_w_q[$];
    logic [W-1:0]    acc_lane_q[$];
    int              done_cyc_q[$];
    int              idle_bad;
    int              ready_extra;
    logic            busy_s0, busy_s1, busy_at_done;

    // Expected queue for the per-accept weights of the current test
    logic [W*DW-1:0] exp_q[$];

    task automatic clear_rec();
        acc_cyc_q.delete();
        acc_idx_q.delete();
        acc_w_q.delete();
        acc_lane_q.delete();
        done_cyc_q.delete();
        exp_q.delete();
        idle_bad    = 0;
        ready_extra = 0;
    endtask

    task automatic preload_pe(input logic [DW-1:0] v);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                pe[r][c] = v;
    endtask

    // Advance one clock, then sample outputs and step the PE array model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = W - 1; r > 0; r--) begin
            for (int c = 0; c < W; c++) begin
                pw[r][c] = pw[r-1][c];
                pi[r][c] = pi[r-1][c];
                pa[r][c] = pa[r-1][c];
            end
        end
        for (int c = 0; c < W; c++) begin
            pw[0][c] = wl_weight_out[c*DW +: DW];
            pi[0][c] = wl_index_out[c*IDXW +: IDXW];
            pa[0][c] = wl_accept_w_out[c];
        end
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (pa[r][c] === 1'b1 && pi[r][c] == IDXW'(r))
                    pe[r][c] = pw[r][c];
        if (wl_accept_w_out != '0) begin
            acc_cyc_q.push_back(cyc - start_cyc);
            acc_idx_q.push_back(wl_index_out);
            acc_w_q.push_back(wl_weight_out);
            acc_lane_q.push_back(wl_accept_w_out);
        end else if (wl_weight_out != '0 || wl_index_out != '0) begin
            idle_bad++;
        end
        if (wl_done === 1'b1) done_cyc_q.push_back(cyc - start_cyc);
    endtask

    // Drive one tile from the current cycle. vpat gives valid per LOAD-phase
    // cycle (bit 0 first), smask pulses a junk wl_start at relative cycle i.
    // Returns in the cycle wl_done is seen, or after a bounded budget.
    task automatic drive_tile(input logic [CNTW-1:0] num, input logic zf,
                              input logic [15:0] vpat, input logic [15:0] smask,
                              input int nload);
        int k;
        int p;
        clear_rec();
        start_cyc    = cyc;
        busy_s0      = wl_busy;
        wl_start     = 1'b1;
        wl_num_rows  = num;
        wl_zero_fill = zf;
        wl_row_valid = 1'b0;
        k = 0;
        p = 0;
        busy_at_done = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) busy_s1 = wl_busy;
            wl_start = (i < 16) ? smask[i] : 1'b0;
            if (wl_start) begin
                wl_num_rows  = 3'd1;
                wl_zero_fill = 1'b1;
            end
            if (done_cyc_q.size() != 0) begin
                busy_at_done = wl_busy;
                wl_row_valid = 1'b0;
                break;
            end
            if (k < nload) begin
                wl_row_valid = (p < 16) ? vpat[p] : 1'b1;
                wl_row_data  = rows[k];
                p++;
            end else begin
                wl_row_valid = 1'b0;
            end
            if (wl_row_ready && wl_row_valid) k++;
            else if (wl_row_ready && k >= nload) ready_extra++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (wl_row_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", wl_row_ready); else passes++;
        checks++; if (wl_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", wl_busy); else passes++;
        checks++; if (wl_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", wl_done); else passes++;
        checks++; if (wl_weight_out !== '0) $display("FAIL reset_weight: got %h expected 0", wl_weight_out); else passes++;
        checks++; if (wl_index_out !== '0) $display("FAIL reset_index: got %h expected 0", wl_index_out); else passes++;
        checks++; if (wl_accept_w_out !== '0) $display("FAIL reset_accept: got %b expected 0", wl_accept_w_out); else passes++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (wl_row_ready !== 1'b0) $display("FAIL idle_ready: got %b expected 0", wl_row_ready); else passes++;
        checks++; if (wl_busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", wl_busy); else passes++;
        checks++; if (wl_state_dbg !== 3'd0) $display("FAIL idle_state: got %0d expected 0", wl_state_dbg); else passes++;
    endtask

    task automatic test_full_rate();
        logic [W*DW-1:0] got;
        preload_pe(8'h00);
        drive_tile(3'd4, 1'b0, 16'hFFFF, 16'h0000, 4);
        for (int j = 0; j < W; j++) exp_q.push_back(rows[j]);
        checks++; if (busy_s0 !== 1'b0) $display("FAIL full_busy_start: got %b expected 0", busy_s0); else passes++;
        checks++; if (busy_s1 !== 1'b1) $display("FAIL full_busy_rise: got %b expected 1", busy_s1); else passes++;
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL full_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        for (int j = 0; j < 4 && j < acc_cyc_q.size(); j++) begin
            checks++; if (acc_cyc_q[j] !== 2 + j) $display("FAIL full_acc_cycle%0d: got %0d expected %0d", j, acc_cyc_q[j], 2 + j); else passes++;
            checks++; if (acc_lane_q[j] !== 4'hF) $display("FAIL full_acc_lanes%0d: got %b expected 1111", j, acc_lane_q[j]); else passes++;
            checks++; if (acc_idx_q[j] !== {W{IDXW'(j)}}) $display("FAIL full_acc_index%0d: got %h expected %h", j, acc_idx_q[j], {W{IDXW'(j)}}); else passes++;
            checks++; if (acc_w_q[j] !== exp_q[j]) $display("FAIL full_acc_weight%0d: got %h expected %h", j, acc_w_q[j], exp_q[j]); else passes++;
        end
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL full_done_cycle: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        checks++; if (idle_bad !== 0) $display("FAIL full_idle_zero: got %0d expected 0", idle_bad); else passes++;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) got[c*DW +: DW] = pe[r][c];
            checks++; if (got !== rows[r]) $display("FAIL full_pe_row%0d: got %h expected %h", r, got, rows[r]); else passes++;
        end
        checks++; if (busy_at_done !== 1'b1) $display("FAIL full_busy_at_done: got %b expected 1", busy_at_done); else passes++;
        tick();
        checks++; if (wl_busy !== 1'b0) $display("FAIL full_busy_fall: got %b expected 0", wl_busy); else passes++;
        checks++; if (wl_done !== 1'b0) $display("FAIL full_done_width: got %b expected 0", wl_done); else passes++;
    endtask

    task automatic test_bubbled();
        int exp_c[4] = '{2, 5, 6, 8};
        tick();
        // valid sequence 1,0,0,1,1,0,1
        drive_tile(3'd4, 1'b0, 16'h0059, 16'h0000, 4);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL bub_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        for (int j = 0; j < 4 && j < acc_cyc_q.size(); j++) begin
            checks++; if (acc_cyc_q[j] !== exp_c[j]) $display("FAIL bub_acc_cycle%0d: got %0d expected %0d", j, acc_cyc_q[j], exp_c[j]); else passes++;
            checks++; if (acc_idx_q[j] !== {W{IDXW'(j)}}) $display("FAIL bub_acc_index%0d: got %h expected %h", j, acc_idx_q[j], {W{IDXW'(j)}}); else passes++;
            checks++; if (acc_w_q[j] !== rows[j]) $display("FAIL bub_acc_weight%0d: got %h expected %h", j, acc_w_q[j], rows[j]); else passes++;
        end
        checks++; if (idle_bad !== 0) $display("FAIL bub_idle_zero: got %0d expected 0", idle_bad); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 12) $display("FAIL bub_done_cycle: got %0d pulses expected done at start+12", done_cyc_q.size()); else passes++;
        tick();
    endtask

    task automatic test_zero_fill();
        logic [W*DW-1:0] got;
        preload_pe(8'h7F);
        tick();
        drive_tile(3'd2, 1'b1, 16'hFFFF, 16'h0000, 2);
        exp_q.push_back(rows[0]);
        exp_q.push_back(rows[1]);
        exp_q.push_back('0);
        exp_q.push_back('0);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL zf_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        for (int j = 0; j < 4 && j < acc_cyc_q.size(); j++) begin
            checks++; if (acc_cyc_q[j] !== 2 + j) $display("FAIL zf_acc_cycle%0d: got %0d expected %0d", j, acc_cyc_q[j], 2 + j); else passes++;
            checks++; if (acc_idx_q[j] !== {W{IDXW'(j)}}) $display("FAIL zf_acc_index%0d: got %h expected %h", j, acc_idx_q[j], {W{IDXW'(j)}}); else passes++;
            checks++; if (acc_w_q[j] !== exp_q[j]) $display("FAIL zf_acc_weight%0d: got %h expected %h", j, acc_w_q[j], exp_q[j]); else passes++;
        end
        checks++; if (ready_extra !== 0) $display("FAIL zf_ready_in_fill: got %0d cycles expected 0", ready_extra); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL zf_done_cycle: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) got[c*DW +: DW] = pe[r][c];
            checks++; if (got !== exp_q[r]) $display("FAIL zf_pe_row%0d: got %h expected %h", r, got, exp_q[r]); else passes++;
        end
        tick();
    endtask

    task automatic test_no_fill();
        logic [W*DW-1:0] got;
        preload_pe(8'h7F);
        tick();
        drive_tile(3'd2, 1'b0, 16'hFFFF, 16'h0000, 2);
        exp_q.push_back(rows[0]);
        exp_q.push_back(rows[1]);
        exp_q.push_back(32'h7F7F7F7F);
        exp_q.push_back(32'h7F7F7F7F);
        checks++; if (acc_cyc_q.size() !== 2) $display("FAIL nf_acc_count: got %0d expected 2", acc_cyc_q.size()); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 7) $display("FAIL nf_done_cycle: got %0d pulses expected done at start+7", done_cyc_q.size()); else passes++;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) got[c*DW +: DW] = pe[r][c];
            checks++; if (got !== exp_q[r]) $display("FAIL nf_pe_row%0d: got %h expected %h", r, got, exp_q[r]); else passes++;
        end
        tick();
    endtask

    task automatic test_clamp();
        tick();
        drive_tile(3'd7, 1'b0, 16'hFFFF, 16'h0000, 4);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL clamp_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        checks++; if (ready_extra !== 0) $display("FAIL clamp_ready_after_w: got %0d cycles expected 0", ready_extra); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL clamp_done_cycle: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        tick();
    endtask

    task automatic test_zero_rows();
        logic [W*DW-1:0] got;
        tick();
        drive_tile(3'd0, 1'b0, 16'hFFFF, 16'h0000, 0);
        checks++; if (acc_cyc_q.size() !== 0) $display("FAIL zr_acc_count: got %0d expected 0", acc_cyc_q.size()); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 2) $display("FAIL zr_done_cycle: got %0d pulses expected done at start+2", done_cyc_q.size()); else passes++;
        preload_pe(8'h7F);
        tick();
        drive_tile(3'd0, 1'b1, 16'hFFFF, 16'h0000, 0);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL zrf_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL zrf_done_cycle: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) got[c*DW +: DW] = pe[r][c];
            checks++; if (got !== '0) $display("FAIL zrf_pe_row%0d: got %h expected 0", r, got); else passes++;
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        clear_rec();
        start_cyc    = cyc;
        wl_start     = 1'b1;
        wl_num_rows  = 3'd4;
        wl_zero_fill = 1'b0;
        wl_row_valid = 1'b0;
        tick();
        wl_start     = 1'b0;
        wl_row_valid = 1'b1;
        wl_row_data  = rows[0];
        tick();
        wl_row_data  = rows[1];
        tick();
        wl_row_valid = 1'b0;
        checks++; if (wl_index_out !== {W{2'd1}}) $display("FAIL rst_pre_index: got %h expected 55", wl_index_out); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wl_accept_w_out !== '0) $display("FAIL rst_async_accept: got %b expected 0", wl_accept_w_out); else passes++;
        checks++; if (wl_weight_out !== '0) $display("FAIL rst_async_weight: got %h expected 0", wl_weight_out); else passes++;
        checks++; if (wl_index_out !== '0) $display("FAIL rst_async_index: got %h expected 0", wl_index_out); else passes++;
        checks++; if (wl_busy !== 1'b0 || wl_row_ready !== 1'b0) $display("FAIL rst_async_busy_ready: got %b%b expected 00", wl_busy, wl_row_ready); else passes++;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_rec();
        repeat (12) tick();
        checks++; if (done_cyc_q.size() !== 0) $display("FAIL rst_no_done: got %0d pulses expected 0", done_cyc_q.size()); else passes++;
        checks++; if (acc_cyc_q.size() !== 0 || wl_busy !== 1'b0) $display("FAIL rst_stays_idle: got %0d accepts busy=%b expected 0 and 0", acc_cyc_q.size(), wl_busy); else passes++;
        drive_tile(3'd4, 1'b0, 16'hFFFF, 16'h0000, 4);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL rst_fresh_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        if (acc_cyc_q.size() != 0) begin
            checks++; if (acc_idx_q[0] !== '0 || acc_w_q[0] !== rows[0]) $display("FAIL rst_fresh_first: got idx %h w %h expected idx 0 w %h", acc_idx_q[0], acc_w_q[0], rows[0]); else passes++;
        end
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL rst_fresh_done: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        tick();
    endtask

    task automatic test_start_ignore();
        tick();
        // junk starts in LOAD (start+2) and in the DONE state cycle (start+8)
        drive_tile(3'd4, 1'b0, 16'hFFFF, 16'h0104, 4);
        checks++; if (acc_cyc_q.size() !== 4) $display("FAIL ign_acc_count: got %0d expected 4", acc_cyc_q.size()); else passes++;
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 9) $display("FAIL ign_done_cycle: got %0d pulses expected done at start+9", done_cyc_q.size()); else passes++;
        // back-to-back: start in the done-pulse cycle
        drive_tile(3'd2, 1'b0, 16'hFFFF, 16'h0000, 2);
        checks++; if (acc_cyc_q.size() !== 2) $display("FAIL b2b_acc_count: got %0d expected 2", acc_cyc_q.size()); else passes++;
        for (int j = 0; j < 2 && j < acc_cyc_q.size(); j++) begin
            checks++; if (acc_cyc_q[j] !== 2 + j || acc_idx_q[j] !== {W{IDXW'(j)}}) $display("FAIL b2b_acc%0d: got cycle %0d idx %h expected cycle %0d idx %h", j, acc_cyc_q[j], acc_idx_q[j], 2 + j, {W{IDXW'(j)}}); else passes++;
        end
        checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 7) $display("FAIL b2b_done_cycle: got %0d pulses expected done at start+7", done_cyc_q.size()); else passes++;
        tick();
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        wl_start     = 1'b0;
        wl_num_rows  = '0;
        wl_zero_fill = 1'b0;
        wl_row_valid = 1'b0;
        wl_row_data  = '0;
        checks       = 0;
        passes       = 0;
        cyc          = 0;
        start_cyc    = 0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                rows[r][c*DW +: DW] = DW'((r << 4) | (c + 1));
                pe[r][c] = '0;
                pw[r][c] = '0;
                pi[r][c] = '0;
                pa[r][c] = 1'b0;
            end
        end
        clear_rec();
        test_reset();
        test_full_rate();
        test_bubbled();
        test_zero_fill();
        test_no_fill();
        test_clamp();
        test_zero_rows();
        test_reset_mid_load();
        test_start_ignore();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
